meas_result_buf: RTL and testbench
==================================

Name: meas_result_buf

Overview:
- Sits directly downstream of the per-channel measurement/demod stage. Consumes its done pulse, hard-decision bits (resultx/resulty) and rotated accumulator values (xacc/yacc).
- Buffers each shot into a FIFO for host readout.
- Holds the latest bit with a valid flag for the sequencer's conditional branching.
- Keeps saturating shot and ones counters for quick state-population estimates.

Parameters:
aw, 6, log2 FIFO depth (depth = 2**aw entries)
DEBUG, "true", mark_debug attribute value on ports

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears FIFO, flags, counters
done  in  1  one-cycle pulse from measurement stage: shot result valid this cycle
resultx  in  1  hard-decision bit (sign of rotated I), sampled when done=1
resulty  in  1  sign of rotated Q, sampled when done=1
xacc  in  32  signed rotated I accumulator, sampled when done=1
yacc  in  32  signed rotated Q accumulator, sampled when done=1
rstrobe  in  1  host pop request
rdata  out  66  popped entry {resulty, resultx, yacc[31:0], xacc[31:0]}
rvalid  out  1  one-cycle pulse: rdata updated this cycle
count  out  aw+1  FIFO occupancy, 0..2**aw
empty  out  1  count==0
full  out  1  count==2**aw
overflow  out  1  sticky: a shot was dropped because the FIFO was full
latest_bit  out  1  resultx of most recent shot
latest_valid  out  1  latest_bit not yet consumed by sequencer
consume  in  1  sequencer acknowledges latest_bit
shots  out  32  number of done pulses since reset, saturating
ones  out  32  number of done pulses with resultx=1 since reset, saturating

Behaviour:
- Reset values, all registered:
  - rdata=0, rvalid=0, count=0, empty=1, full=0, overflow=0
  - latest_bit=0, latest_valid=0, shots=0, ones=0
  - FIFO read and write pointers = 0
- Reset overrides every other input in the same cycle, including done, rstrobe and consume.
- Reset asserted mid-operation discards all FIFO contents. No rvalid is produced for a pop issued in the reset cycle.

FIFO:
- Storage is a 2**aw x 66 array, preferring distributed or block RAM with a registered read.
- Push: done=1 and (not full, or pop accepted in the same cycle) -> write {resulty,resultx,yacc,xacc} at wptr; wptr+1, wrapping modulo 2**aw.
- Push when full with no same-cycle pop: entry dropped, overflow<=1, pointers and count unchanged.
- Pop: rstrobe=1 and not empty -> rdata<=mem[rptr] on the next edge, rvalid=1 for exactly that cycle; rptr+1, wrapping.
  - Read latency is 1 cycle from the rstrobe edge to rvalid.
  - rdata holds its value until the next accepted pop.
- Pop when empty: ignored. rvalid stays 0, no state change. This also applies when a push happens in the same cycle: push accepted, pop ignored, and the entry is readable next cycle.
- Push and pop in the same cycle with 0<count<2**aw: both performed, count unchanged.
- Push and pop in the same cycle at full: both performed, count stays 2**aw, overflow not set.
- count, empty and full are registered and consistent with the pointers every cycle. Pointers carry an extra MSB to distinguish full from empty.

Sequencer handshake:
- done=1 -> latest_bit<=resultx, latest_valid<=1. This happens regardless of FIFO full.
- consume=1 and done=0 -> latest_valid<=0.
- consume and done in the same cycle: done wins (latest_valid=1, new bit).
- consume while latest_valid=0: no effect.

Statistics:
- done=1 -> shots<=shots+1 unless shots==32'hFFFFFFFF (saturate).
- done=1 and resultx=1 -> ones<=ones+1, saturating likewise.
- Counters are independent of FIFO state. Dropped shots are still counted.

Timing:
- No combinational paths from inputs to outputs.
- done is a single-cycle pulse. Back-to-back done pulses on consecutive cycles must each be accepted.

Test Plan:
- Reset, then 3 done pulses with (resultx, xacc, yacc) = (1, 100, -5), (0, -7, 3), (1, 0x7FFFFFFF, 0x80000000) -> count=3, shots=3, ones=2. Three pops return the entries in order, each with rvalid exactly one cycle after rstrobe, and empty=1 after the last pop.
- aw=2: 5 back-to-back done pulses -> full=1 after the 4th, overflow=1 after the 5th, count=4, shots=5. Pops return the first 4 entries only.
- Full FIFO with done and rstrobe in the same cycle -> count stays 4, overflow stays 0, the oldest entry is popped, and the new entry appears as the last pop.
- Empty FIFO with done and rstrobe in the same cycle -> no rvalid, count=1. The next rstrobe returns that entry.
- done with resultx=1 -> latest_valid=1, latest_bit=1. consume -> latest_valid=0. Then done(resultx=0) in the same cycle as consume -> latest_valid=1, latest_bit=0.
- Force shots=ones=32'hFFFFFFFE, then apply 3 done pulses with resultx=1 -> both counters hold 32'hFFFFFFFF. reset asserted mid-sequence with count=2 -> next cycle count=0, empty=1, all counters 0.

Source files
------------

// File: rtl/meas_result_buf.sv
// Per-shot result FIFO (2**aw x 66, one-cycle registered read), latest-bit handshake for the sequencer, saturating stats.
// done is never backpressured: a shot arriving at a full FIFO without a same-cycle pop is dropped and flagged in sticky overflow.
module meas_result_buf #(
  parameter int aw    = 6,
  parameter     DEBUG = "true"
) (
  (* mark_debug = DEBUG *) input  logic          clk,
  (* mark_debug = DEBUG *) input  logic          reset,
  (* mark_debug = DEBUG *) input  logic          done,
  (* mark_debug = DEBUG *) input  logic          resultx,
  (* mark_debug = DEBUG *) input  logic          resulty,
  (* mark_debug = DEBUG *) input  logic [31:0]   xacc,
  (* mark_debug = DEBUG *) input  logic [31:0]   yacc,
  (* mark_debug = DEBUG *) input  logic          rstrobe,
  (* mark_debug = DEBUG *) output logic [65:0]   rdata,
  (* mark_debug = DEBUG *) output logic          rvalid,
  (* mark_debug = DEBUG *) output logic [aw:0]   count,
  (* mark_debug = DEBUG *) output logic          empty,
  (* mark_debug = DEBUG *) output logic          full,
  (* mark_debug = DEBUG *) output logic          overflow,
  (* mark_debug = DEBUG *) output logic          latest_bit,
  (* mark_debug = DEBUG *) output logic          latest_valid,
  (* mark_debug = DEBUG *) input  logic          consume,
  (* mark_debug = DEBUG *) output logic [31:0]   shots,
  (* mark_debug = DEBUG *) output logic [31:0]   ones
);

  localparam int          depth   = 2 ** aw;
  localparam logic [aw:0] depth_c = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] one_c   = {{aw{1'b0}}, 1'b1};

  logic [65:0] mem [depth];
  logic [aw:0] wptr;
  logic [aw:0] rptr;
  logic [aw:0] count_nxt;
  logic        push_ok;
  logic        pop_ok;

  // A pop at full frees the slot being written, so the push is still accepted.
  assign pop_ok  = rstrobe && !empty;
  assign push_ok = done && (!full || pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + one_c;
      2'b01:   count_nxt = count - one_c;
      default: count_nxt = count;
    endcase
  end

  // Storage kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wptr[aw-1:0]] <= {resulty, resultx, yacc, xacc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rvalid <= pop_ok;
      if (pop_ok) begin
        rdata <= mem[rptr[aw-1:0]];
        rptr  <= rptr + one_c;
      end
      if (push_ok) begin
        wptr <= wptr + one_c;
      end else if (done) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == depth_c);
    end
  end

  // New shot beats a same-cycle consume so the sequencer never misses a bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      latest_bit   <= 1'b0;
      latest_valid <= 1'b0;
    end else if (done) begin
      latest_bit   <= resultx;
      latest_valid <= 1'b1;
    end else if (consume) begin
      latest_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shots <= '0;
      ones  <= '0;
    end else if (done) begin
      if (shots != 32'hFFFF_FFFF) shots <= shots + 32'd1;
      if (resultx && (ones != 32'hFFFF_FFFF)) ones <= ones + 32'd1;
    end
  end

endmodule

// File: tb/tb_meas_result_buf.sv
// Directed bench for meas_result_buf (aw=2): a queue holds expected pops, a monitor checks rdata and rvalid timing.
module tb_meas_result_buf;

  localparam int aw    = 2;
  localparam int depth = 2 ** aw;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          done = 1'b0;
  logic          resultx = 1'b0;
  logic          resulty = 1'b0;
  logic [31:0]   xacc = '0;
  logic [31:0]   yacc = '0;
  logic          rstrobe = 1'b0;
  logic          consume = 1'b0;
  logic [65:0]   rdata;
  logic          rvalid;
  logic [aw:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          latest_bit;
  logic          latest_valid;
  logic [31:0]   shots;
  logic [31:0]   ones;

  meas_result_buf #(.aw(aw), .DEBUG("true")) dut (
    .clk(clk), .reset(reset), .done(done), .resultx(resultx), .resulty(resulty),
    .xacc(xacc), .yacc(yacc), .rstrobe(rstrobe), .rdata(rdata), .rvalid(rvalid),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .latest_bit(latest_bit), .latest_valid(latest_valid), .consume(consume),
    .shots(shots), .ones(ones)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [65:0] mq[$];
  logic [65:0] exp_dat[$];
  int          exp_cyc[$];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected pop, on the promised cycle.
  always @(posedge clk) begin
    #1;
    if (rvalid === 1'b1) begin
      if (exp_dat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%0h at cycle %0d expected no pop", rdata, cyc);
      end else begin
        chk("rdata", rdata, exp_dat.pop_front());
        chk("rvalid_latency", 66'(cyc), 66'(exp_cyc.pop_front()));
      end
    end
  end

  task automatic drive(input logic d, input logic rx, input logic ry,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic rs, input logic cons, input logic rst);
    bit pop_ok;
    bit push_ok;
    done = d; resultx = rx; resulty = ry; xacc = x; yacc = y;
    rstrobe = rs; consume = cons; reset = rst;
    if (rst) begin
      mq.delete();
    end else begin
      pop_ok  = rs && (mq.size() > 0);
      push_ok = d && ((mq.size() < depth) || pop_ok);
      if (pop_ok) begin
        exp_dat.push_back(mq.pop_front());
        exp_cyc.push_back(cyc + 1);
      end
      if (push_ok) mq.push_back({ry, rx, y, x});
    end
    @(posedge clk);
    #1;
    done = 1'b0; rstrobe = 1'b0; consume = 1'b0; reset = 1'b0;
  endtask

  task automatic shot(input logic rx, input logic [31:0] x, input logic [31:0] y);
    drive(1'b1, rx, y[31], x, y, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_rdata", rdata, 66'd0);
    chk("rst_rvalid", 66'(rvalid), 66'd0);
    chk("rst_count", 66'(count), 66'd0);
    chk("rst_empty", 66'(empty), 66'd1);
    chk("rst_full", 66'(full), 66'd0);
    chk("rst_overflow", 66'(overflow), 66'd0);
    chk("rst_latest_bit", 66'(latest_bit), 66'd0);
    chk("rst_latest_valid", 66'(latest_valid), 66'd0);
    chk("rst_shots", 66'(shots), 66'd0);
    chk("rst_ones", 66'(ones), 66'd0);

    // Three shots, then three back-to-back pops.
    shot(1'b1, 32'd100, 32'hFFFF_FFFB);
    shot(1'b0, 32'hFFFF_FFF9, 32'd3);
    shot(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("t1_count", 66'(count), 66'd3);
    chk("t1_shots", 66'(shots), 66'd3);
    chk("t1_ones", 66'(ones), 66'd2);
    chk("t1_empty", 66'(empty), 66'd0);
    pop(); pop(); pop();
    idle();
    chk("t1_empty_after", 66'(empty), 66'd1);
    chk("t1_count_after", 66'(count), 66'd0);
    chk("t1_rdata_hold", rdata, {1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF});

    // Five back-to-back shots into a depth-4 FIFO.
    for (int i = 0; i < 5; i++) begin
      shot(1'(i), 32'(i + 10), 32'(i));
      if (i == 3) begin
        chk("t2_full_at4", 66'(full), 66'd1);
        chk("t2_ovf_at4", 66'(overflow), 66'd0);
      end
    end
    chk("t2_overflow", 66'(overflow), 66'd1);
    chk("t2_count", 66'(count), 66'd4);
    chk("t2_full", 66'(full), 66'd1);
    chk("t2_shots", 66'(shots), 66'd8);
    chk("t2_ones", 66'(ones), 66'd4);
    for (int i = 0; i < 4; i++) pop();
    idle();
    chk("t2_empty", 66'(empty), 66'd1);
    chk("t2_ovf_sticky", 66'(overflow), 66'd1);
    chk("t2_rdata_last", rdata, {1'b0, 1'b1, 32'd3, 32'd13});

    do_reset();
    chk("rst2_overflow", 66'(overflow), 66'd0);
    chk("rst2_shots", 66'(shots), 66'd0);

    // Full FIFO with push and pop together.
    for (int i = 0; i < 4; i++) shot(1'b0, 32'(i + 20), 32'd0);
    chk("t3_full_pre", 66'(full), 66'd1);
    drive(1'b1, 1'b1, 1'b1, 32'd99, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 66'(count), 66'd4);
    chk("t3_full", 66'(full), 66'd1);
    chk("t3_overflow", 66'(overflow), 66'd0);
    for (int i = 0; i < 4; i++) pop();
    idle();
    chk("t3_rdata_new_last", rdata, {1'b1, 1'b1, 32'hFFFF_FFFF, 32'd99});
    chk("t3_empty", 66'(empty), 66'd1);

    // Empty FIFO with push and pop together: pop ignored.
    drive(1'b1, 1'b0, 1'b0, 32'd55, 32'd66, 1'b1, 1'b0, 1'b0);
    chk("t4_rvalid", 66'(rvalid), 66'd0);
    chk("t4_count", 66'(count), 66'd1);
    chk("t4_empty", 66'(empty), 66'd0);
    pop();
    idle();
    chk("t4_rdata", rdata, {1'b0, 1'b0, 32'd66, 32'd55});
    chk("t4_count_after", 66'(count), 66'd0);

    // Sequencer handshake.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_consume0", 66'(latest_valid), 66'd0);
    shot(1'b1, 32'd1, 32'd1);
    chk("t5_lv1", 66'(latest_valid), 66'd1);
    chk("t5_lb1", 66'(latest_bit), 66'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_consumed", 66'(latest_valid), 66'd0);
    chk("t5_lb_kept", 66'(latest_bit), 66'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0);
    chk("t5_done_wins_lv", 66'(latest_valid), 66'd1);
    chk("t5_done_wins_lb", 66'(latest_bit), 66'd0);

    // Reset mid-operation with two entries queued; pop, push and consume in the reset cycle.
    chk("t6_count_pre", 66'(count), 66'd2);
    drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1);
    chk("t6_count", 66'(count), 66'd0);
    chk("t6_empty", 66'(empty), 66'd1);
    chk("t6_rvalid", 66'(rvalid), 66'd0);
    chk("t6_shots", 66'(shots), 66'd0);
    chk("t6_ones", 66'(ones), 66'd0);
    chk("t6_lv", 66'(latest_valid), 66'd0);
    chk("t6_rdata", rdata, 66'd0);
    idle();
    chk("t6_no_late_rvalid", 66'(rvalid), 66'd0);

    // Counter saturation.
    force dut.shots = 32'hFFFF_FFFE;
    force dut.ones  = 32'hFFFF_FFFE;
    #1;
    release dut.shots;
    release dut.ones;
    shot(1'b1, 32'd1, 32'd0);
    chk("t7_shots_step", 66'(shots), 66'h0_FFFF_FFFF);
    chk("t7_ones_step", 66'(ones), 66'h0_FFFF_FFFF);
    shot(1'b1, 32'd2, 32'd0);
    shot(1'b1, 32'd3, 32'd0);
    chk("t7_shots_sat", 66'(shots), 66'h0_FFFF_FFFF);
    chk("t7_ones_sat", 66'(ones), 66'h0_FFFF_FFFF);
    chk("t7_count", 66'(count), 66'd3);
    for (int i = 0; i < 3; i++) pop();
    idle();
    idle();

    checks++;
    if (exp_dat.size() != 0) begin
      errors++;
      $display("FAIL missing_rvalid: got %0d pops outstanding expected 0", exp_dat.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
